// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline skid latch: state encoding,
// default widths and the state-to-occupancy decode.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int DATA_W_DEFAULT = 32;
    localparam int CNT_W_DEFAULT  = 16;

    // Live-entry count implied by each state; unused encodings report empty.
    function automatic logic [1:0] state_occupancy(input state_t s);
        logic [1:0] occ;
        case (s)
            EMPTY:   occ = 2'd0;
            BUSY:    occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter import pipe_pkg::*; #(
    parameter int WIDTH = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise step unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {WIDTH{1'b0}};
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_latch.sv
// Two-entry pipeline skid latch: main register drives the output, skid register
// absorbs one beat so in_ready depends on state only.
module pipe_skid_latch import pipe_pkg::*; #(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_s;
    logic              out_valid_s;
    logic              xfer_in_s;
    logic              xfer_out_s;

    // Handshake flags decoded purely from the state register.
    always_comb begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        case (state_q)
            EMPTY: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            BUSY: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b1;
            end
            FULL: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
        endcase
    end

    assign xfer_in_s  = in_valid & in_ready_s;
    assign xfer_out_s = out_valid_s & out_ready;

    // Next state and data movement; flush squashes everything.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = {DATA_W{1'b0}};
            skid_d  = {DATA_W{1'b0}};
        end else begin
            case (state_q)
                EMPTY: begin
                    if (xfer_in_s) begin
                        main_d  = in_data;
                        state_d = BUSY;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                BUSY: begin
                    if (xfer_in_s && xfer_out_s) begin
                        main_d  = in_data;
                        state_d = BUSY;
                    end else if (xfer_in_s) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (xfer_out_s) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = BUSY;
                    end
                end
                FULL: begin
                    // Input is blocked while full; a drain promotes the skid entry.
                    if (xfer_out_s) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end else begin
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = {DATA_W{1'b0}};
                    skid_d  = {DATA_W{1'b0}};
                end
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= EMPTY;
            main_q  <= {DATA_W{1'b0}};
            skid_q  <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (out_valid_s & ~out_ready),
        .clear (1'b0),
        .count (stall_cnt)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = main_q;
    assign occupancy = state_occupancy(state_q);

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Directed bench for pipe_skid_latch: default instance plus a CNT_W=2 instance
// sharing the same stimulus for the saturation scenario.
module tb_pipe_skid_latch;

    logic        CLK;
    logic        nRST;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  occupancy2;
    logic [1:0]  stall_cnt2;

    int passed;
    int total;

    pipe_skid_latch dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_skid_latch #(.DATA_W(32), .CNT_W(2)) dut2 (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0h want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0h want 1", in_ready); else passed++;
        total++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy got %0d want 0", occupancy); else passed++;
        total++; if (out_data !== 32'h0) $display("FAIL reset_out_data got %0h want 0", out_data); else passed++;
        total++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); else passed++;
        step();
        step();
        nRST = 1'b1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 32'hA5A5A5A5; out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got %0h want 1", out_valid); else passed++;
        total++; if (out_data !== 32'hA5A5A5A5) $display("FAIL single_out_data got %0h want a5a5a5a5", out_data); else passed++;
        total++; if (occupancy !== 2'd1) $display("FAIL single_occupancy got %0d want 1", occupancy); else passed++;
        in_valid = 1'b0;
        step();
        total++; if (occupancy !== 2'd0) $display("FAIL single_drain got %0d want 0", occupancy); else passed++;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_data = 32'(k);
            step();
            total++; if (out_valid !== 1'b1 || out_data !== 32'(k))
                $display("FAIL stream_data beat %0d got v=%0h d=%0h want v=1 d=%0h", k, out_valid, out_data, k); else passed++;
            total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready beat %0d got %0h want 1", k, in_ready); else passed++;
        end
        in_valid = 1'b0;
        step();
        total++; if (occupancy !== 2'd0) $display("FAIL stream_drain got %0d want 0", occupancy); else passed++;
        total++; if (stall_cnt !== 16'd0) $display("FAIL stream_stall_cnt got %0d want 0", stall_cnt); else passed++;
    endtask

    task automatic test_back_to_back_fill();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h10;
        step();
        in_data = 32'h11;
        step();
        total++; if (occupancy !== 2'd2) $display("FAIL fill_occupancy got %0d want 2", occupancy); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got %0h want 0", in_ready); else passed++;
        in_data = 32'h12;
        step();
        total++; if (out_data !== 32'h10 || occupancy !== 2'd2)
            $display("FAIL fill_blocked got d=%0h occ=%0d want d=10 occ=2", out_data, occupancy); else passed++;
        total++; if (stall_cnt !== 16'd2) $display("FAIL fill_stall_cnt got %0d want 2", stall_cnt); else passed++;
        out_ready = 1'b1;
        step();
        total++; if (out_data !== 32'h11 || occupancy !== 2'd1)
            $display("FAIL fill_drain1 got d=%0h occ=%0d want d=11 occ=1", out_data, occupancy); else passed++;
        step();
        total++; if (out_data !== 32'h12 || occupancy !== 2'd1)
            $display("FAIL fill_drain2 got d=%0h occ=%0d want d=12 occ=1", out_data, occupancy); else passed++;
        in_valid = 1'b0;
        step();
        total++; if (occupancy !== 2'd0) $display("FAIL fill_empty got %0d want 0", occupancy); else passed++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h20;
        step();
        in_data = 32'h21;
        step();
        flush = 1'b1; in_data = 32'h99;
        step();
        total++; if (occupancy !== 2'd0) $display("FAIL flush_occupancy got %0d want 0", occupancy); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %0h want 0", out_valid); else passed++;
        total++; if (out_data !== 32'h0) $display("FAIL flush_out_data got %0h want 0", out_data); else passed++;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (out_valid !== 1'b0 || out_data === 32'h99)
                $display("FAIL flush_no_ghost cycle %0d got v=%0h d=%0h want v=0", i, out_valid, out_data); else passed++;
        end
    endtask

    task automatic test_stall_saturate();
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        flush = 1'b0; in_valid = 1'b1; in_data = 32'h30; out_ready = 1'b0;
        step();
        total++; if (stall_cnt2 !== 2'd0) $display("FAIL sat_start got %0d want 0", stall_cnt2); else passed++;
        in_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            total++; if (stall_cnt2 !== 2'((i > 3) ? 3 : i))
                $display("FAIL sat_cnt2 cycle %0d got %0d want %0d", i, stall_cnt2, (i > 3) ? 3 : i); else passed++;
            total++; if (stall_cnt !== 16'(i)) $display("FAIL sat_cnt16 cycle %0d got %0d want %0d", i, stall_cnt, i); else passed++;
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        total++; if (stall_cnt2 !== 2'd3) $display("FAIL sat_after_flush got %0d want 3", stall_cnt2); else passed++;
        total++; if (stall_cnt !== 16'd7) $display("FAIL cnt16_after_flush got %0d want 7", stall_cnt); else passed++;
        total++; if (occupancy2 !== 2'd0) $display("FAIL sat_flush_occ got %0d want 0", occupancy2); else passed++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h40;
        step();
        in_data = 32'h41;
        step();
        total++; if (occupancy !== 2'd2) $display("FAIL areset_pre_full got %0d want 2", occupancy); else passed++;
        #2;
        nRST = 1'b0;
        #1;
        total++; if (occupancy !== 2'd0) $display("FAIL areset_occupancy got %0d want 0", occupancy); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready got %0h want 1", in_ready); else passed++;
        total++; if (stall_cnt !== 16'd0) $display("FAIL areset_stall_cnt got %0d want 0", stall_cnt); else passed++;
        total++; if (out_data !== 32'h0) $display("FAIL areset_out_data got %0h want 0", out_data); else passed++;
        nRST = 1'b1; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
        step();
        total++; if (out_data !== 32'h55 || occupancy !== 2'd1)
            $display("FAIL areset_restart got d=%0h occ=%0d want d=55 occ=1", out_data, occupancy); else passed++;
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_single();
        test_stream();
        test_back_to_back_fill();
        test_flush();
        test_stall_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_skid_latch.md
PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits (the packed stage bundle).
REQ-002 Parameter CNT_W, default 16, stall-counter width in bits.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous squash of all held entries.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_ready  output  1  block can accept in_data this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 out_valid  output  1  out_data holds a live entry.
REQ-010 out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 out_data  output  DATA_W  head payload.
REQ-012 occupancy  output  2  live entries held, 0..2.
REQ-013 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 Storage SHALL be a main register plus one skid register; out_data SHALL always drive the main register.
REQ-015 States SHALL be EMPTY (0 entries), BUSY (main live), FULL (main and skid live); occupancy SHALL equal 0/1/2 respectively.
REQ-016 in_ready SHALL be 1 in EMPTY and BUSY and 0 in FULL, decoded from state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 in BUSY and FULL and 0 in EMPTY.
REQ-018 Transfer-in SHALL occur when in_valid and in_ready are both 1; transfer-out SHALL occur when out_valid and out_ready are both 1.
REQ-019 EMPTY with transfer-in: main<=in_data; next state BUSY; latency from in_valid to out_valid SHALL be 1 cycle.
REQ-020 BUSY with transfer-in and transfer-out: main<=in_data; state stays BUSY (sustained throughput of 1 entry/cycle).
REQ-021 BUSY with transfer-in only: skid<=in_data; next state FULL.
REQ-022 BUSY with transfer-out only: next state EMPTY.
REQ-023 FULL with transfer-out: main<=skid; next state BUSY; in_valid is ignored that cycle.
REQ-024 With no transfer, state and both data registers SHALL hold unchanged.
REQ-025 flush=1 SHALL have priority over every transfer: next state EMPTY, both data registers cleared to 0, the offered input dropped, and any same-cycle transfer-out still counted as consumed by downstream.
REQ-026 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and be unaffected by flush.
REQ-027 Ordering SHALL be strictly FIFO: no entry is lost, duplicated or reordered except by flush.

Reset
REQ-028 On nRST=0, asynchronously: state EMPTY, main=0, skid=0, stall_cnt=0, hence out_valid=0, in_ready=1, occupancy=0, out_data=0.
REQ-029 Reset asserted mid-operation SHALL discard all held entries; the first rising edge after deassertion SHALL behave as EMPTY.

Structure
REQ-030 The state enum typedef (EMPTY, BUSY, FULL) SHALL reside in shared package pipe_pkg, alongside the default DATA_W and CNT_W constants.
REQ-031 The saturating counter SHALL be the sub-module sat_counter (parameter width; inputs inc and clear; output count); all other logic SHALL be flat.

Verification
REQ-032 Reset, then in_valid=1, in_data=0xA5A5A5A5, out_ready=1 -> out_valid=1 with out_data=0xA5A5A5A5 one cycle later; occupancy=1.
REQ-033 Stream 0x1,0x2,0x3,0x4 on consecutive cycles with out_ready=1 -> output 0x1..0x4 on consecutive cycles; in_ready stays 1; stall_cnt=0.
REQ-034 Load 0x10, then 0x11 with out_ready=0 -> occupancy=2, in_ready=0; 0x12 offered is not accepted; out_ready=1 -> 0x10, then 0x11, then 0x12.
REQ-035 FULL state, then flush=1 with in_valid=1, in_data=0x99 -> next cycle occupancy=0, out_valid=0, out_data=0; 0x99 never appears at the output.
REQ-036 CNT_W=2, out_valid held with out_ready=0 for 6 cycles -> stall_cnt reads 1,2,3,3,3,3; a following flush leaves it at 3.
REQ-037 nRST pulsed low mid-cycle while FULL -> immediately occupancy=0, in_ready=1, stall_cnt=0, without waiting for a clock edge.
